// File: rtl/fifo_reader_pkg.sv
// Shared types and defaults for the FIFO read-side consumer (fifo_reader).
package fifo_reader_pkg;

    typedef enum logic [1:0] {IDLE, RUN, STOP} rd_state_t;

    localparam int XFER_CNT_W     = 16;
    localparam int DEF_FIFO_WIDTH = 16;
    localparam int DEF_BUF_DEPTH  = 4;

endpackage

// File: rtl/fifo_reader_if.sv
// FIFO read port plus outgoing stream of fifo_reader, bundled for one port connection.
interface fifo_reader_if #(
    parameter int FIFO_WIDTH = fifo_reader_pkg::DEF_FIFO_WIDTH
);
    // FIFO side: fifo_rd_en is honoured only while !fifo_empty; fifo_data_out is valid the
    // cycle after. Stream side: a word moves on every cycle where m_valid && m_ready; once
    // m_valid is raised, m_valid and m_data hold until that transfer happens.
    logic                  fifo_empty;
    logic                  fifo_underflow;
    logic [FIFO_WIDTH-1:0] fifo_data_out;
    logic                  fifo_rd_en;
    logic                  m_valid;
    logic [FIFO_WIDTH-1:0] m_data;
    logic                  m_ready;

    modport master (
        input  fifo_empty, fifo_underflow, fifo_data_out, m_ready,
        output fifo_rd_en, m_valid, m_data
    );

    modport slave (
        output fifo_empty, fifo_underflow, fifo_data_out, m_ready,
        input  fifo_rd_en, m_valid, m_data
    );
endinterface

// File: rtl/reader_skid_buf.sv
// Ring buffer between FIFO read data and the output stream; any DEPTH >= 2 is supported.
module reader_skid_buf #(
    parameter  int WIDTH = 16,
    parameter  int DEPTH = 4,
    localparam int OCC_W = $clog2(DEPTH + 1),
    localparam int PTR_W = $clog2(DEPTH)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push,
    input  logic [WIDTH-1:0] push_data,
    input  logic             pop,
    output logic [WIDTH-1:0] head_data,
    output logic [OCC_W-1:0] occ
);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PTR_W-1:0] head;
    logic [PTR_W-1:0] tail;

    // Compare-and-clear so depths that are not a power of two wrap correctly.
    function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
        return (p == PTR_W'(DEPTH - 1)) ? '0 : p + PTR_W'(1);
    endfunction

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
            head <= '0;
            tail <= '0;
            occ  <= '0;
        end else begin
            if (push) begin
                mem[tail] <= push_data;
                tail      <= ptr_inc(tail);
            end
            if (pop) head <= ptr_inc(head);
            case ({push, pop})
                2'b10:   occ <= occ + OCC_W'(1);
                2'b01:   occ <= occ - OCC_W'(1);
                default: ;
            endcase
        end
    end

    assign head_data = mem[head];

endmodule

// File: rtl/fifo_reader.sv
// Drains the FIFO read port into a small buffer and serves it as a valid/ready stream.
// Define FIFO_READER_STATS_EN to implement xfer_count and err_underflow (tied to 0 otherwise).
module fifo_reader
    import fifo_reader_pkg::*;
#(
    parameter int FIFO_WIDTH = DEF_FIFO_WIDTH,
    parameter int BUF_DEPTH  = DEF_BUF_DEPTH
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  en,
    fifo_reader_if.master         bus,
    output logic                  busy,
    output logic [XFER_CNT_W-1:0] xfer_count,
    output logic                  err_underflow,
    output rd_state_t             dbg_state
);

    localparam int OCC_W = $clog2(BUF_DEPTH + 1);
    localparam logic [OCC_W:0] DEPTH_V = BUF_DEPTH[OCC_W:0];

    rd_state_t             state;
    rd_state_t             state_nxt;
    logic                  inflight;
    logic                  rd_req;
    logic                  pop;
    logic [OCC_W-1:0]      occ;
    logic [OCC_W:0]        committed;
    logic [FIFO_WIDTH-1:0] head_data;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= IDLE;
        else     state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (en) state_nxt = RUN;
            RUN:     if (!en) state_nxt = STOP;
            STOP: begin
                if (en)             state_nxt = RUN;
                else if (!inflight) state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    // A read is only issued when the word it returns is guaranteed a buffer slot,
    // so the request never looks at m_ready.
    always_comb begin
        committed = {1'b0, occ} + {{OCC_W{1'b0}}, inflight};
        rd_req    = (state == RUN) && !bus.fifo_empty && (committed < DEPTH_V);
        busy      = (state != IDLE) || (occ != '0);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) inflight <= 1'b0;
        else     inflight <= rd_req;
    end

    assign bus.fifo_rd_en = rd_req;
    assign bus.m_valid    = (occ != '0);
    assign bus.m_data     = head_data;
    assign pop            = bus.m_valid && bus.m_ready;
    assign dbg_state      = state;

    reader_skid_buf #(
        .WIDTH (FIFO_WIDTH),
        .DEPTH (BUF_DEPTH)
    ) u_buf (
        .clk       (clk),
        .rst       (rst),
        .push      (inflight),
        .push_data (bus.fifo_data_out),
        .pop       (pop),
        .head_data (head_data),
        .occ       (occ)
    );

`ifdef FIFO_READER_STATS_EN
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            xfer_count    <= '0;
            err_underflow <= 1'b0;
        end else begin
            if (pop) xfer_count <= xfer_count + XFER_CNT_W'(1);
            if (bus.fifo_underflow && rd_req) err_underflow <= 1'b1;
        end
    end
`else
    logic unused_underflow;
    assign unused_underflow = bus.fifo_underflow;
    assign xfer_count       = '0;
    assign err_underflow    = 1'b0;
`endif

endmodule

// File: tb/tb_fifo_reader.sv
// Bench for fifo_reader: vector table, directed corner sequences and a randomized run,
// all scored against a queue model of the FIFO contents and the expected stream order.
module tb_fifo_reader;
    import fifo_reader_pkg::*;

    localparam int W = 16;
`ifdef FIFO_READER_STATS_EN
    localparam bit STATS_ON = 1'b1;
`else
    localparam bit STATS_ON = 1'b0;
`endif

    typedef struct {
        int           n_words;
        logic         en;
        logic         ready;
        int           cycles;
        int           exp_reads;
        int           exp_pops;
        logic         exp_valid;
        logic [W-1:0] exp_head;
    } vec_t;

    logic clk = 1'b0;
    logic rst;
    logic en4, en2;
    logic busy4, busy2, err4, err2;
    logic [XFER_CNT_W-1:0] xc4, xc2;
    rd_state_t st4, st2;

    fifo_reader_if #(.FIFO_WIDTH(W)) bus4 ();
    fifo_reader_if #(.FIFO_WIDTH(W)) bus2 ();

    fifo_reader #(.FIFO_WIDTH(W), .BUF_DEPTH(4)) u_dut4 (
        .clk(clk), .rst(rst), .en(en4), .bus(bus4.master), .busy(busy4),
        .xfer_count(xc4), .err_underflow(err4), .dbg_state(st4)
    );

    fifo_reader #(.FIFO_WIDTH(W), .BUF_DEPTH(2)) u_dut2 (
        .clk(clk), .rst(rst), .en(en2), .bus(bus2.master), .busy(busy2),
        .xfer_count(xc2), .err_underflow(err2), .dbg_state(st2)
    );

    always #5 clk = ~clk;

    int n_pass = 0;
    int n_total = 0;
    int cyc = 0;
    logic [W-1:0] fq4[$], fq2[$];
    logic [W-1:0] exp_q4[$], exp_q2[$];
    logic rd_s[2], pop_s[2], hold_v[2], err_m[2];
    logic [W-1:0] hold_d[2];
    int rd_cnt[2], pop_cnt[2];
    vec_t vecs[6];
    int first_rd, first_v, last_pop, last_rd, n_rd, run, max_run;
    logic seen, hit;

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        n_total++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, got, exp, cyc);
    endtask

    function automatic logic [W-1:0] exp_xfer(input int d);
        return STATS_ON ? W'(pop_cnt[d]) : '0;
    endfunction

    function automatic logic exp_err(input int d);
        return STATS_ON ? err_m[d] : 1'b0;
    endfunction

    task automatic clear_model();
        fq4.delete(); fq2.delete(); exp_q4.delete(); exp_q2.delete();
        for (int d = 0; d < 2; d++) begin
            rd_s[d] = 1'b0; pop_s[d] = 1'b0; hold_v[d] = 1'b0; err_m[d] = 1'b0;
            hold_d[d] = '0; rd_cnt[d] = 0; pop_cnt[d] = 0;
        end
        bus4.fifo_empty = 1'b1; bus2.fifo_empty = 1'b1;
        bus4.fifo_data_out = '0; bus2.fifo_data_out = '0;
    endtask

    task automatic preload(input int d, input int n, input logic [W-1:0] base);
        for (int i = 0; i < n; i++) begin
            if (d == 0) fq4.push_back(base + W'(i));
            else        fq2.push_back(base + W'(i));
        end
        bus4.fifo_empty = (fq4.size() == 0);
        bus2.fifo_empty = (fq2.size() == 0);
    endtask

    task automatic sample_one(input int d, input logic rd, input logic valid, input logic ready,
                              input logic empty, input logic underflow, input logic [W-1:0] data);
        logic [W-1:0] e;
        int avail;
        rd_s[d]  = rd;
        pop_s[d] = valid && ready;
        if (empty) check($sformatf("rd_when_empty%0d", d), rd, 1'b0);
        if (hold_v[d]) begin
            check($sformatf("hold_valid%0d", d), valid, 1'b1);
            check($sformatf("hold_data%0d", d), data, hold_d[d]);
        end
        if (pop_s[d]) begin
            avail = (d == 0) ? exp_q4.size() : exp_q2.size();
            check($sformatf("pop_has_word%0d", d), avail != 0, 1'b1);
            if (avail != 0) begin
                e = (d == 0) ? exp_q4.pop_front() : exp_q2.pop_front();
                check($sformatf("pop_data%0d", d), data, e);
            end
        end
        if (underflow && rd) err_m[d] = 1'b1;
        hold_v[d] = valid && !ready;
        hold_d[d] = data;
    endtask

    task automatic sample();
        @(negedge clk);
        sample_one(0, bus4.fifo_rd_en, bus4.m_valid, bus4.m_ready, bus4.fifo_empty,
                   bus4.fifo_underflow, bus4.m_data);
        sample_one(1, bus2.fifo_rd_en, bus2.m_valid, bus2.m_ready, bus2.fifo_empty,
                   bus2.fifo_underflow, bus2.m_data);
    endtask

    task automatic advance();
        logic [W-1:0] w;
        @(posedge clk);
        #1;
        cyc++;
        if (rd_s[0] && fq4.size() != 0) begin
            w = fq4.pop_front(); bus4.fifo_data_out = w; exp_q4.push_back(w);
        end
        if (rd_s[1] && fq2.size() != 0) begin
            w = fq2.pop_front(); bus2.fifo_data_out = w; exp_q2.push_back(w);
        end
        for (int d = 0; d < 2; d++) begin
            if (rd_s[d])  rd_cnt[d]++;
            if (pop_s[d]) pop_cnt[d]++;
            rd_s[d] = 1'b0; pop_s[d] = 1'b0;
        end
        bus4.fifo_empty = (fq4.size() == 0);
        bus2.fifo_empty = (fq2.size() == 0);
    endtask

    task automatic cycle();
        sample();
        advance();
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst = 1'b1;
        en4 = 1'b0; en2 = 1'b0;
        bus4.m_ready = 1'b0; bus2.m_ready = 1'b0;
        bus4.fifo_underflow = 1'b0; bus2.fifo_underflow = 1'b0;
        clear_model();
        @(posedge clk);
        #1;
        rst = 1'b0;
    endtask

    initial begin
        vecs[0] = '{n_words:0, en:1'b1, ready:1'b0, cycles:8,  exp_reads:0, exp_pops:0, exp_valid:1'b0, exp_head:16'h0000};
        vecs[1] = '{n_words:2, en:1'b1, ready:1'b0, cycles:10, exp_reads:2, exp_pops:0, exp_valid:1'b1, exp_head:16'h0201};
        vecs[2] = '{n_words:4, en:1'b1, ready:1'b0, cycles:10, exp_reads:4, exp_pops:0, exp_valid:1'b1, exp_head:16'h0301};
        vecs[3] = '{n_words:8, en:1'b1, ready:1'b0, cycles:12, exp_reads:4, exp_pops:0, exp_valid:1'b1, exp_head:16'h0401};
        vecs[4] = '{n_words:3, en:1'b1, ready:1'b1, cycles:12, exp_reads:3, exp_pops:3, exp_valid:1'b0, exp_head:16'h0000};
        vecs[5] = '{n_words:6, en:1'b0, ready:1'b1, cycles:10, exp_reads:0, exp_pops:0, exp_valid:1'b0, exp_head:16'h0000};

        // Reset values, asserted from time zero.
        rst = 1'b1; en4 = 1'b0; en2 = 1'b0;
        bus4.m_ready = 1'b0; bus2.m_ready = 1'b0;
        bus4.fifo_underflow = 1'b0; bus2.fifo_underflow = 1'b0;
        clear_model();
        #1;
        check("rst_rd_en", bus4.fifo_rd_en, 1'b0);
        check("rst_valid", bus4.m_valid, 1'b0);
        check("rst_data", bus4.m_data, 16'h0000);
        check("rst_busy", busy4, 1'b0);
        check("rst_xfer", xc4, 16'h0000);
        check("rst_err", err4, 1'b0);
        check("rst_state", st4, IDLE);
        check("rst_valid2", bus2.m_valid, 1'b0);
        @(posedge clk);
        #1;
        rst = 1'b0;

        for (int i = 0; i < 6; i++) begin
            do_reset();
            preload(0, vecs[i].n_words, W'(((i + 1) << 8) + 1));
            en4 = vecs[i].en;
            bus4.m_ready = vecs[i].ready;
            repeat (vecs[i].cycles) cycle();
            check($sformatf("vec%0d_reads", i), rd_cnt[0], vecs[i].exp_reads);
            check($sformatf("vec%0d_pops", i), pop_cnt[0], vecs[i].exp_pops);
            check($sformatf("vec%0d_valid", i), bus4.m_valid, vecs[i].exp_valid);
            if (vecs[i].exp_valid) check($sformatf("vec%0d_head", i), bus4.m_data, vecs[i].exp_head);
        end

        // Streaming 0x0001..0x0008 with the sink always ready.
        do_reset();
        preload(0, 8, 16'h0001);
        en4 = 1'b1; bus4.m_ready = 1'b1;
        first_rd = -1; first_v = -1; last_pop = -1;
        for (int i = 0; i < 30; i++) begin
            sample();
            if (rd_s[0] && first_rd < 0) first_rd = cyc;
            if (bus4.m_valid && first_v < 0) first_v = cyc;
            if (pop_s[0]) begin
                if (last_pop >= 0) check("stream_gap", cyc - last_pop, 1);
                last_pop = cyc;
            end
            advance();
        end
        check("stream_latency", first_v - first_rd, 2);
        check("stream_pops", pop_cnt[0], 8);
        check("stream_left", exp_q4.size(), 0);
        check("stream_xfer", xc4, exp_xfer(0));

        // Backpressure: 8 words queued, sink stalled, then released.
        do_reset();
        preload(0, 8, 16'h0001);
        en4 = 1'b1; bus4.m_ready = 1'b0;
        repeat (12) cycle();
        check("bp_reads", rd_cnt[0], 4);
        check("bp_valid", bus4.m_valid, 1'b1);
        check("bp_head", bus4.m_data, 16'h0001);
        bus4.m_ready = 1'b1;
        repeat (16) cycle();
        check("bp_pops", pop_cnt[0], 8);
        check("bp_left", exp_q4.size(), 0);

        // en dropped in the same cycle as a read request.
        do_reset();
        preload(0, 5, 16'h0021);
        bus4.m_ready = 1'b1; en4 = 1'b1;
        seen = 1'b0;
        for (int i = 0; i < 20; i++) begin
            sample();
            if (rd_s[0] && !seen) begin
                seen = 1'b1;
                en4 = 1'b0;
            end
            advance();
        end
        check("stop_seen", seen, 1'b1);
        check("stop_reads", rd_cnt[0], 1);
        check("stop_pops", pop_cnt[0], 1);
        check("stop_state", st4, IDLE);
        check("stop_busy", busy4, 1'b0);
        check("stop_fifo_left", fq4.size(), 4);

        // Depth-2 instance: read rate bounded by the two buffer slots, order intact.
        do_reset();
        preload(1, 8, 16'h0031);
        en2 = 1'b1; bus2.m_ready = 1'b1;
        n_rd = 0; run = 0; max_run = 0; first_rd = -1; last_rd = -1;
        for (int i = 0; i < 40; i++) begin
            sample();
            if (rd_s[1]) begin
                if (first_rd < 0) first_rd = cyc;
                last_rd = cyc;
                n_rd++;
                run++;
                if (run > max_run) max_run = run;
            end else begin
                run = 0;
            end
            advance();
        end
        check("hr_reads", n_rd, 8);
        check("hr_no_burst3", max_run <= 2, 1'b1);
        check("hr_span", (last_rd - first_rd) <= 14, 1'b1);
        check("hr_pops", pop_cnt[1], 8);
        check("hr_left", exp_q2.size(), 0);
        check("hr_xfer", xc2, exp_xfer(1));

        // Underflow reported by the FIFO while a read is issued.
        do_reset();
        preload(0, 4, 16'h0051);
        en4 = 1'b1; bus4.m_ready = 1'b1; bus4.fifo_underflow = 1'b1;
        seen = 1'b0;
        for (int i = 0; i < 10 && !seen; i++) begin
            sample();
            seen = rd_s[0];
            advance();
        end
        bus4.fifo_underflow = 1'b0;
        check("uf_seen", seen, 1'b1);
        check("uf_set", err4, exp_err(0));
        repeat (8) cycle();
        check("uf_sticky", err4, exp_err(0));
        do_reset();
        check("uf_cleared", err4, 1'b0);

        // Reset with two words buffered and one in flight.
        do_reset();
        preload(0, 8, 16'h0061);
        en4 = 1'b1; bus4.m_ready = 1'b0;
        hit = 1'b0;
        for (int i = 0; i < 20 && !hit; i++) begin
            sample();
            if (rd_s[0] && rd_cnt[0] == 3) hit = 1'b1;
            else advance();
        end
        check("mid_hit", hit, 1'b1);
        check("mid_valid_before", bus4.m_valid, 1'b1);
        rst = 1'b1;
        #1;
        check("mid_rd_en", bus4.fifo_rd_en, 1'b0);
        check("mid_valid", bus4.m_valid, 1'b0);
        check("mid_data", bus4.m_data, 16'h0000);
        check("mid_busy", busy4, 1'b0);
        check("mid_xfer", xc4, 16'h0000);
        check("mid_err", err4, 1'b0);
        en4 = 1'b0;
        clear_model();
        @(posedge clk);
        #1;
        rst = 1'b0;
        #1;
        check("mid_state_after", st4, IDLE);
        check("mid_valid_after", bus4.m_valid, 1'b0);

        // Randomized en / m_ready / FIFO refill, then a full drain.
        do_reset();
        for (int i = 0; i < 40; i++) fq4.push_back(W'($urandom));
        bus4.fifo_empty = 1'b0;
        for (int i = 0; i < 400; i++) begin
            en4 = ($urandom_range(0, 7) != 0);
            bus4.m_ready = ($urandom_range(0, 2) != 0);
            if ($urandom_range(0, 5) == 0) begin
                fq4.push_back(W'($urandom));
                bus4.fifo_empty = 1'b0;
            end
            cycle();
        end
        en4 = 1'b1; bus4.m_ready = 1'b1;
        for (int i = 0; i < 300 && (fq4.size() != 0 || exp_q4.size() != 0); i++) cycle();
        check("rand_fifo_drained", fq4.size(), 0);
        check("rand_stream_drained", exp_q4.size(), 0);
        check("rand_count_match", pop_cnt[0], rd_cnt[0]);
        check("rand_xfer", xc4, exp_xfer(0));
        check("rand_err", err4, 1'b0);
        en4 = 1'b0;
        repeat (4) cycle();
        check("rand_state_idle", st4, IDLE);
        check("rand_busy", busy4, 1'b0);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
